exec_sequencer: RTL
===================

# exec_sequencer

Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, the execute unit, an optional data-memory access, and writeback. It sits beside the execute datapath. It generates the enables for the PC register, the instruction register, the execute-result register, data memory, and the register file. It stalls on a handshaked memory and stops on HALT or on an execute-unit error. It also keeps a 16-bit retired-instruction count for the demo harness.

## Interface
Parameters:
- `RETIRE_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 5: instr[15:11] from the instruction register; valid from DECODE onward.
- `mem_done` in 1: memory completion strobe; sampled only while `mem_en`=1.
- `ex_err` in 1: error flag from the execute unit; sampled only in EXEC.
- `mem_en` out 1: memory request, held high until `mem_done`.
- `mem_wr` out 1: 1 = store access; valid only with `mem_en` in MEM.
- `mem_sel_d` out 1: 0 = instruction address (PC), 1 = data address (execute result).
- `ir_en` out 1: load the instruction register.
- `ex_en` out 1: latch execute result and `pc_updated`.
- `rf_wr_en` out 1: register-file write.
- `pc_en` out 1: load PC from the latched `pc_updated`.
- `halted` out 1: sticky; HALT retired.
- `err` out 1: sticky; `ex_err` seen in EXEC.
- `retired` out RETIRE_W: retired-instruction count.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Outputs are a Moore decode of the registered state, except `ir_en` and `pc_en`, which are qualified by `mem_done` as noted.
- IDLE: all outputs 0. Always goes to FETCH on the next cycle.
- FETCH: `mem_en`=1, `mem_sel_d`=0.
  - `mem_done`=1: `ir_en`=1 this cycle, go to DECODE.
  - `mem_done`=0: stay in FETCH.
- DECODE: no enables. One cycle.
  - opcode 00000 (HALT): go to HALT; `pc_en`=1 this cycle; `retired` increments.
  - opcode 00001 (NOP): `pc_en`=1, `retired`++, go to FETCH.
  - All other opcodes: go to EXEC.
- EXEC: `ex_en`=1. One cycle.
  - `ex_err`=1: go to ERR. No `pc_en`, no `rf_wr_en`, `retired` unchanged.
  - LD 10001, ST 10000, STU 10011: go to MEM.
  - Branches 011xx, J 00100, JR 00101: `pc_en`=1, `retired`++, go to FETCH.
  - All others, including JAL 00110 and JALR 00111: go to WB.
- MEM: `mem_en`=1, `mem_sel_d`=1, `mem_wr`=1 for ST/STU. Hold until `mem_done`.
  - ST: on `mem_done`, `pc_en`=1, `retired`++, go to FETCH.
  - LD/STU: on `mem_done`, go to WB.
- WB: `rf_wr_en`=1, `pc_en`=1, `retired`++. One cycle, then FETCH.
- HALT and ERR are terminal. All enables are 0; `halted` (HALT) or `err` (ERR) stays at 1. Only `rst` exits.
- `retired` wraps modulo 2^RETIRE_W with no saturation. It increments exactly once per retired instruction, in the cycle `pc_en`=1.

## Timing
- Reset (`rst`=1 at an edge): state becomes IDLE, `retired`=0, `halted`=0, `err`=0. All outputs are 0 on the following cycle.
- `rst` takes priority over every other input, including a `mem_done` in the same cycle. Reset in the middle of a memory access abandons the request: `mem_en` is 0 the cycle after.
- Minimum latencies, with `mem_done` returned in the same cycle as the request:
  - NOP: 2 cycles.
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch/J/JR: 3 cycles.
  - ST: 4 cycles.
  - LD: 5 cycles.
- Each memory wait cycle adds exactly one cycle.
- `mem_en` never drops between request and `mem_done`.
- Back-to-back accesses (MEM → FETCH) deassert `mem_en` for 0 cycles. `mem_sel_d` changes on the state transition.
- `pc_en` is asserted for exactly one cycle per instruction. `ir_en` is asserted for exactly one cycle per fetch.

## Structure
- Shared include `exec_seq_defs.vh`: state encodings and the opcode constants HALT, NOP, ST, LD, STU, J, JR, JAL, JALR, and the branch prefix 011. The decoder and the bench share this file.
- Sub-module `retire_counter`:
  - RETIRE_W-bit register with synchronous reset and increment enable.
  - Driven by the same term as `pc_en`, excluding the HALT-state path.
- State register and next-state/output logic live in `exec_sequencer`.

## Test plan
- Reset, then `rst` deasserted: `state`=IDLE for 1 cycle, then FETCH; `mem_en`=1; `retired`=0.
- ADD (opcode 11011) with `mem_done` tied to 1: states 1→2→3→5→1. `rf_wr_en` and `pc_en` each pulse once. `retired`=1 after 4 cycles.
- LD with `mem_done` delayed 3 cycles in both FETCH and MEM:
  - 11 cycles total.
  - `mem_en` continuous through each wait.
  - `mem_sel_d`=1 only in MEM.
  - `retired`=1.
- BEQZ, then ST: no `rf_wr_en` pulse for either; `mem_wr`=1 only during ST's MEM; `retired`=2 after 7 cycles.
- `ex_err`=1 in EXEC: `err`=1 and `state`=7 from the next cycle; no `pc_en` or `rf_wr_en`; holds for 20 cycles; `rst` clears it to IDLE.
- HALT after 0xFFFF NOPs: `retired` wraps to 0x0000 and `halted`=1. `rst` asserted together with `mem_done` mid-FETCH goes to IDLE and the IR is not loaded.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encodings, opcode
// constants and opcode class helpers used by the sequencer and its bench.
package exec_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } seq_state_t;

   localparam logic [4:0] OP_HALT = 5'b00000;
   localparam logic [4:0] OP_NOP  = 5'b00001;
   localparam logic [4:0] OP_J    = 5'b00100;
   localparam logic [4:0] OP_JR   = 5'b00101;
   localparam logic [4:0] OP_JAL  = 5'b00110;
   localparam logic [4:0] OP_JALR = 5'b00111;
   localparam logic [4:0] OP_ST   = 5'b10000;
   localparam logic [4:0] OP_LD   = 5'b10001;
   localparam logic [4:0] OP_STU  = 5'b10011;
   localparam logic [2:0] OP_BR_PREFIX = 3'b011;

   function automatic logic op_is_mem(input logic [4:0] op);
      return (op == OP_LD) || (op == OP_ST) || (op == OP_STU);
   endfunction

   // Control transfers retire straight out of EXEC; JAL/JALR still need WB.
   function automatic logic op_is_ctl(input logic [4:0] op);
      return (op[4:2] == OP_BR_PREFIX) || (op == OP_J) || (op == OP_JR);
   endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^RETIRE_W.
module retire_counter #(
   parameter int RETIRE_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc_en,
   output logic [RETIRE_W-1:0] count
);

   logic [RETIRE_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst)
         count_reg <= '0;
      else if (inc_en)
         count_reg <= count_reg + RETIRE_W'(1);
   end

   assign count = count_reg;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer. Enables are a
// decode of the registered state; ir_en and pc_en also follow mem_done/opcode.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int RETIRE_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          opcode,
   input  logic                mem_done,
   input  logic                ex_err,
   output logic                mem_en,
   output logic                mem_wr,
   output logic                mem_sel_d,
   output logic                ir_en,
   output logic                ex_en,
   output logic                rf_wr_en,
   output logic                pc_en,
   output logic                halted,
   output logic                err,
   output logic [RETIRE_W-1:0] retired,
   output logic [2:0]          state
);

   seq_state_t state_reg, state_next;
   logic       store_reg, store_next;
   logic       st_only_reg, st_only_next;
   logic       ir_load, pc_load;

   always_comb begin
      state_next   = state_reg;
      store_next   = store_reg;
      st_only_next = st_only_reg;
      mem_en       = 1'b0;
      mem_wr       = 1'b0;
      mem_sel_d    = 1'b0;
      ex_en        = 1'b0;
      rf_wr_en     = 1'b0;
      ir_load      = 1'b0;
      pc_load      = 1'b0;
      case (state_reg)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            mem_en = 1'b1;
            if (mem_done) begin
               ir_load    = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (opcode == OP_HALT) begin
               pc_load    = 1'b1;
               state_next = S_HALT;
            end else if (opcode == OP_NOP) begin
               pc_load    = 1'b1;
               state_next = S_FETCH;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            ex_en = 1'b1;
            if (ex_err) begin
               state_next = S_ERR;
            end else if (op_is_mem(opcode)) begin
               // Remember the access kind so MEM does not depend on opcode timing.
               store_next   = (opcode == OP_ST) || (opcode == OP_STU);
               st_only_next = (opcode == OP_ST);
               state_next   = S_MEM;
            end else if (op_is_ctl(opcode)) begin
               pc_load    = 1'b1;
               state_next = S_FETCH;
            end else begin
               state_next = S_WB;
            end
         end
         S_MEM: begin
            mem_en    = 1'b1;
            mem_sel_d = 1'b1;
            mem_wr    = store_reg;
            if (mem_done) begin
               if (st_only_reg) begin
                  pc_load    = 1'b1;
                  state_next = S_FETCH;
               end else begin
                  state_next = S_WB;
               end
            end
         end
         S_WB: begin
            rf_wr_en   = 1'b1;
            pc_load    = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: state_next = S_HALT;
         S_ERR:  state_next = S_ERR;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         store_reg   <= 1'b0;
         st_only_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         store_reg   <= store_next;
         st_only_reg <= st_only_next;
      end
   end

   // Reset wins over a same-cycle mem_done: no IR or PC load while rst is high.
   assign ir_en  = ir_load & ~rst;
   assign pc_en  = pc_load & ~rst;
   assign halted = (state_reg == S_HALT);
   assign err    = (state_reg == S_ERR);
   assign state  = state_reg;

   retire_counter #(
      .RETIRE_W(RETIRE_W)
   ) u_retire_counter (
      .clk   (clk),
      .rst   (rst),
      .inc_en(pc_en),
      .count (retired)
   );

endmodule
